// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: issues one memory read at a time, buffers returned words with
// their PCs in a small prefetch queue, and handles redirects and EBREAK halting.
module fetch_sequencer #(
   parameter logic [31:0] RESET_PC    = 32'h0000_0000,
   parameter int unsigned QUEUE_DEPTH = 2
) (
   input  logic        clk,
   input  logic        rst,
   output logic        mem_req,
   output logic [31:0] mem_addr,
   input  logic        mem_ack,
   input  logic [31:0] mem_data,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_instr,
   output logic [31:0] out_pc,
   output logic        halted
);

   localparam int unsigned PW     = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
   localparam logic [PW:0] DepthC = (PW + 1)'(QUEUE_DEPTH);
   localparam logic [31:0] Ebreak = 32'h0010_0073;

   typedef enum logic [1:0] {StIdle, StReq, StDrain, StHalt} state_t;

   state_t        state_q, state_d;
   logic [31:0]   fetch_pc_q, fetch_pc_d;
   logic [31:0]   drain_addr_q, drain_addr_d;
   logic [31:0]   q_pc    [QUEUE_DEPTH];
   logic [31:0]   q_instr [QUEUE_DEPTH];
   logic [PW-1:0] wr_ptr_q, rd_ptr_q;
   logic [PW:0]   count_q, cnt_after;
   logic [31:0]   hold_pc_q, hold_instr_q;
   logic          push, pop;
   logic [1:0]    unused_redirect_lsb;

   assign unused_redirect_lsb = redirect_pc[1:0];

   assign out_valid = (count_q != '0);
   assign out_pc    = out_valid ? q_pc[rd_ptr_q] : hold_pc_q;
   assign out_instr = out_valid ? q_instr[rd_ptr_q] : hold_instr_q;
   assign mem_req   = (state_q == StReq) || (state_q == StDrain);
   // A drained request must keep its original address even though fetch_pc has moved on.
   assign mem_addr  = (state_q == StDrain) ? drain_addr_q : fetch_pc_q;
   assign halted    = (state_q == StHalt) && (count_q == '0);

   assign pop       = out_valid & out_ready & ~redirect_valid;
   assign push      = (state_q == StReq) & mem_ack & ~redirect_valid;
   assign cnt_after = count_q + (PW + 1)'(push) - (PW + 1)'(pop);

   always_comb begin
      state_d      = state_q;
      fetch_pc_d   = fetch_pc_q;
      drain_addr_d = drain_addr_q;
      if (redirect_valid) begin
         fetch_pc_d = {redirect_pc[31:2], 2'b00};
         if ((state_q == StReq || state_q == StDrain) && !mem_ack) begin
            state_d = StDrain;
            if (state_q == StReq) drain_addr_d = fetch_pc_q;
         end else begin
            state_d = StIdle;
         end
      end else begin
         unique case (state_q)
            StIdle: begin
               if (count_q < DepthC || pop) state_d = StReq;
            end
            StReq: begin
               if (mem_ack) begin
                  fetch_pc_d = fetch_pc_q + 32'd4;
                  if (mem_data == Ebreak)    state_d = StHalt;
                  else if (cnt_after < DepthC) state_d = StReq;
                  else                       state_d = StIdle;
               end
            end
            StDrain: begin
               if (mem_ack) state_d = StIdle;
            end
            StHalt:  state_d = StHalt;
            default: state_d = StIdle;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= StIdle;
         fetch_pc_q   <= RESET_PC;
         drain_addr_q <= RESET_PC;
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         count_q      <= '0;
         hold_pc_q    <= '0;
         hold_instr_q <= '0;
      end else begin
         state_q      <= state_d;
         fetch_pc_q   <= fetch_pc_d;
         drain_addr_q <= drain_addr_d;
         if (out_valid) begin
            hold_pc_q    <= out_pc;
            hold_instr_q <= out_instr;
         end
         if (redirect_valid) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
         end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= cnt_after;
         end
      end
   end

   // Storage needs no reset: entries are only visible once written.
   always_ff @(posedge clk) begin
      if (push) begin
         q_pc[wr_ptr_q]    <= fetch_pc_q;
         q_instr[wr_ptr_q] <= mem_data;
      end
   end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer: memory model with programmable latency, scoreboard
// of expected {pc, instr} entries, a scenario table and hand-written corner sequences.
module tb_fetch_sequencer;

   localparam logic [31:0] Ebreak = 32'h0010_0073;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        mem_req, mem_ack, redirect_valid, out_valid, out_ready, halted;
   logic [31:0] mem_addr, mem_data, redirect_pc, out_instr, out_pc;

   always #5 clk = ~clk;

   fetch_sequencer #(
      .RESET_PC   (32'h0000_0000),
      .QUEUE_DEPTH(2)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .mem_req       (mem_req),
      .mem_addr      (mem_addr),
      .mem_ack       (mem_ack),
      .mem_data      (mem_data),
      .redirect_valid(redirect_valid),
      .redirect_pc   (redirect_pc),
      .out_valid     (out_valid),
      .out_ready     (out_ready),
      .out_instr     (out_instr),
      .out_pc        (out_pc),
      .halted        (halted)
   );

   int tests  = 0;
   int errors = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // Stimulus controls, written by the main sequence just after a rising edge.
   int          lat       = 0;
   int          ready_pct = 100;
   logic [31:0] ebreak_pc = 32'h0000_1000;
   int          redir_mode = 0;  // 0 none, 1 next cycle, 2 on the next ack cycle
   logic [31:0] redir_target = '0;

   // Model state
   typedef struct packed {logic [31:0] pc; logic [31:0] instr;} entry_t;
   entry_t      sb[$];
   entry_t      e;
   bit          busy, discard, halt_exp, ack, redir;
   int          wait_cnt, ack_count, pop_count;
   logic [31:0] req_addr, exp_addr, last_pop_pc;

   function automatic logic [31:0] word_at(input logic [31:0] a, input logic [31:0] brk);
      return (a == brk) ? Ebreak : (32'hA500_0000 | a);
   endfunction

   always @(negedge clk) begin
      if (rst) begin
         sb.delete();
         busy = 0; discard = 0; halt_exp = 0;
         wait_cnt = 0; ack_count = 0; pop_count = 0;
         exp_addr = 32'h0; req_addr = 32'h0; last_pop_pc = 32'h0;
         mem_ack = 1'b0; mem_data = 32'h0; redirect_valid = 1'b0; out_ready = 1'b0;
      end else begin
         check("out_valid", {31'b0, out_valid}, {31'b0, sb.size() != 0});
         check("halted", {31'b0, halted}, {31'b0, halt_exp && sb.size() == 0});
         if (halt_exp) check("no_req_after_ebreak", {31'b0, mem_req}, 32'd0);
         if (mem_req && !busy) begin
            check("req_addr", mem_addr, exp_addr);
            busy = 1; req_addr = mem_addr; wait_cnt = lat;
         end else if (busy) begin
            check("req_held", {31'b0, mem_req}, 32'd1);
            check("addr_stable", mem_addr, req_addr);
         end
         ack = busy && wait_cnt == 0;
         if (busy && wait_cnt > 0) wait_cnt--;
         mem_ack  = ack;
         mem_data = ack ? word_at(req_addr, ebreak_pc) : 32'hDEAD_BEEF;
         redir = (redir_mode == 1) || (redir_mode == 2 && ack);
         redirect_valid = redir;
         redirect_pc    = redir_target;
         out_ready      = ($urandom_range(99) < ready_pct);
         if (redir) begin
            redir_mode = 0;
            sb.delete();
            exp_addr = {redir_target[31:2], 2'b00};
            halt_exp = 0;
            if (ack) begin
               busy = 0; discard = 0; ack_count++;
            end else if (busy) begin
               discard = 1;
            end
         end else begin
            if (out_valid && out_ready) begin
               if (sb.size() == 0) begin
                  check("unexpected_output", out_pc, 32'hFFFF_FFFF);
               end else begin
                  e = sb.pop_front();
                  check("out_pc", out_pc, e.pc);
                  check("out_instr", out_instr, e.instr);
               end
               pop_count++;
               last_pop_pc = out_pc;
            end
            if (ack) begin
               busy = 0; ack_count++;
               if (discard) begin
                  discard = 0;
               end else begin
                  sb.push_back({req_addr, word_at(req_addr, ebreak_pc)});
                  exp_addr = req_addr + 32'd4;
                  if (word_at(req_addr, ebreak_pc) == Ebreak) halt_exp = 1;
               end
            end
         end
      end
   end

   task automatic do_reset();
      @(posedge clk); #1;
      rst = 1'b1;
      @(negedge clk); @(negedge clk);
      @(posedge clk); #1;
      rst = 1'b0;
   endtask

   task automatic step();
      @(posedge clk); #1;
   endtask

   typedef struct {
      int          lat;
      int          ready_pct;
      logic [31:0] ebreak_pc;
      int          exp_pops;
      logic [31:0] exp_last_pc;
   } scen_t;

   scen_t tbl[5];
   int    n;

   initial begin
      mem_ack = 1'b0; mem_data = '0; redirect_valid = 1'b0; redirect_pc = '0; out_ready = 1'b0;
      tbl[0] = '{0, 100, 32'h1C, 8, 32'h1C};
      tbl[1] = '{3, 100, 32'h1C, 8, 32'h1C};
      tbl[2] = '{1, 50, 32'h28, 11, 32'h28};
      tbl[3] = '{2, 30, 32'h10, 5, 32'h10};
      tbl[4] = '{0, 60, 32'h3C, 16, 32'h3C};

      // Reset values while rst is held
      #2;
      check("rst_mem_req", {31'b0, mem_req}, 32'd0);
      check("rst_mem_addr", mem_addr, 32'h0);
      check("rst_out_valid", {31'b0, out_valid}, 32'd0);
      check("rst_out_instr", out_instr, 32'h0);
      check("rst_out_pc", out_pc, 32'h0);
      check("rst_halted", {31'b0, halted}, 32'd0);

      for (int i = 0; i < 5; i++) begin
         lat = tbl[i].lat; ready_pct = tbl[i].ready_pct; ebreak_pc = tbl[i].ebreak_pc;
         do_reset();
         n = 0;
         while (!halted && n < 2000) begin step(); n++; end
         check("scen_halted", {31'b0, halted}, 32'd1);
         check("scen_pops", pop_count, tbl[i].exp_pops);
         check("scen_last_pc", last_pop_pc, tbl[i].exp_last_pc);
      end

      // Zero latency streaming: first request on 2nd edge, then no bubbles
      lat = 0; ready_pct = 100; ebreak_pc = 32'h1000;
      do_reset();
      check("first_req_early", {31'b0, mem_req}, 32'd0);
      step();
      check("first_req", {31'b0, mem_req}, 32'd1);
      check("first_addr", mem_addr, 32'h0);
      n = 0;
      while (!out_valid && n < 20) begin step(); n++; end
      check("stream_pc0", out_pc, 32'h0);
      for (int k = 1; k < 6; k++) begin
         step();
         check("stream_valid", {31'b0, out_valid}, 32'd1);
         check("stream_pc", out_pc, 32'(k * 4));
         check("stream_req", {31'b0, mem_req}, 32'd1);
      end

      // Latency 3 with a stalled consumer: queue fills after exactly two acks
      lat = 3; ready_pct = 0;
      do_reset();
      repeat (30) step();
      check("full_acks", ack_count, 32'd2);
      check("full_no_req", {31'b0, mem_req}, 32'd0);
      check("full_valid", {31'b0, out_valid}, 32'd1);
      check("full_head", out_pc, 32'h0);
      ready_pct = 100;
      n = 0;
      while (!mem_req && n < 20) begin step(); n++; end
      check("resume_addr", mem_addr, 32'h8);

      // Redirect while the request to 0x8 is pending
      lat = 3; ready_pct = 100;
      do_reset();
      n = 0;
      while (!(mem_req && mem_addr == 32'h8) && n < 50) begin step(); n++; end
      check("pending_8", mem_addr, 32'h8);
      redir_target = 32'h43; redir_mode = 1;
      n = 0;
      while (redir_mode != 0 && n < 10) begin step(); n++; end
      check("redir_flush", {31'b0, out_valid}, 32'd0);
      n = 0;
      while (!out_valid && n < 50) begin step(); n++; end
      check("redir_first_pc", out_pc, 32'h40);

      // Redirect on the same edge as an ack
      lat = 2; ready_pct = 100;
      do_reset();
      repeat (10) step();
      redir_target = 32'h80; redir_mode = 2;
      n = 0;
      while (redir_mode != 0 && n < 20) begin step(); n++; end
      n = 0;
      while (!out_valid && n < 50) begin step(); n++; end
      check("ackredir_first_pc", out_pc, 32'h80);

      // EBREAK at 0x1C, then redirect out of HALT
      lat = 1; ready_pct = 100; ebreak_pc = 32'h1C;
      do_reset();
      n = 0;
      while (!halted && n < 200) begin step(); n++; end
      check("halt_set", {31'b0, halted}, 32'd1);
      check("halt_no_req", {31'b0, mem_req}, 32'd0);
      check("halt_last_pc", last_pop_pc, 32'h1C);
      redir_target = 32'h0; redir_mode = 1;
      n = 0;
      while (redir_mode != 0 && n < 10) begin step(); n++; end
      check("halt_cleared", {31'b0, halted}, 32'd0);
      n = 0;
      while (!out_valid && n < 50) begin step(); n++; end
      check("restart_pc", out_pc, 32'h0);

      // Reset during an outstanding request
      lat = 6; ready_pct = 0; ebreak_pc = 32'h1000;
      do_reset();
      n = 0;
      while (!(out_valid && mem_req) && n < 50) begin step(); n++; end
      check("pre_rst_busy", {31'b0, out_valid && mem_req}, 32'd1);
      rst = 1'b1;
      #1;
      check("async_mem_req", {31'b0, mem_req}, 32'd0);
      check("async_out_valid", {31'b0, out_valid}, 32'd0);
      check("async_mem_addr", mem_addr, 32'h0);
      @(negedge clk); @(negedge clk);
      step();
      rst = 1'b0;
      ready_pct = 100;
      check("post_rst_idle", {31'b0, mem_req}, 32'd0);
      step();
      check("post_rst_req", {31'b0, mem_req}, 32'd1);
      check("post_rst_addr", mem_addr, 32'h0);
      repeat (30) step();

      $display("[TB] %0d tests run, %0d failed", tests, errors);
      $finish;
   end

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
- Sequences instruction reads from the word-addressed instruction memory on behalf of the core front end.
- Holds the fetch PC and issues one read at a time over a req/ack handshake.
- Buffers returned words with their PCs in a small prefetch queue, presented to decode over valid/ready.
- Handles branch/jump redirects (flush) and stops prefetching after an EBREAK (32'h00100073) word enters the queue.

Parameters:
- RESET_PC, 32'h0000_0000: fetch PC loaded at reset; bits [1:0] must be 0.
- QUEUE_DEPTH, 2: prefetch queue entries; power of two, 2..8.

Ports:
- clk  in  1  system clock, all state on rising edge
- rst  in  1  asynchronous active-high reset
- mem_req  out  1  read request to instruction memory
- mem_addr  out  32  byte address of request, word aligned
- mem_ack  in  1  memory returns data this cycle
- mem_data  in  32  instruction word, valid when mem_ack=1
- redirect_valid  in  1  one-cycle pulse: flush and restart at redirect_pc
- redirect_pc  in  32  new fetch address; bits [1:0] ignored, forced to 0
- out_valid  out  1  queue head valid
- out_ready  in  1  decode accepts head
- out_instr  out  32  head instruction word
- out_pc  out  32  head instruction address
- halted  out  1  EBREAK fetched, queue drained, no request outstanding

Behaviour:
- Reset (async, immediate on rst=1):
  - mem_req=0, mem_addr=RESET_PC, out_valid=0, out_instr=0, out_pc=0, halted=0.
  - Queue empty, fetch_pc=RESET_PC, state=IDLE.
- States: IDLE, REQ, DRAIN, HALT.
- IDLE:
  - Goes to REQ when queue count < QUEUE_DEPTH.
  - mem_req is registered: it asserts the cycle after the space condition is seen.
  - First request after reset appears on the 2nd rising edge after rst deasserts.
- REQ:
  - mem_req=1, mem_addr=fetch_pc, both held stable until mem_ack is sampled 1.
  - Only one request is outstanding at a time.
  - On ack: push {fetch_pc, mem_data} into the queue; fetch_pc += 4 (32-bit wrap from FFFF_FFFC to 0).
  - After ack: if mem_data==32'h00100073, go to HALT; else if space remains after the push and pop of that same edge, stay in REQ (back-to-back, mem_req stays 1 with the new address); else go to IDLE.
- Memory latency is arbitrary, including 0: ack may be high in the first cycle of mem_req.
- Queue:
  - FIFO. out_valid = count!=0; out_instr/out_pc show the head.
  - Pop on out_valid & out_ready.
  - Push and pop on the same edge leaves count unchanged.
  - Overflow cannot occur: issue is gated by count, with the same-edge pop counted as freeing space.
  - Pop when empty is ignored.
  - When empty, out_instr/out_pc hold their last values.
- Redirect (highest priority; wins over a simultaneous ack, push or pop):
  - Queue flushed that edge (out_valid=0 next cycle); fetch_pc <= {redirect_pc[31:2],2'b00}.
  - If a request is outstanding and not acked that edge, go to DRAIN. Otherwise go to IDLE.
  - If mem_ack is 1 in the redirect cycle, the returned word is discarded.
- DRAIN:
  - mem_req stays 1 with the old address (a request cannot be withdrawn).
  - The word returned on ack is discarded, then go to IDLE.
  - A further redirect in DRAIN only updates fetch_pc.
- HALT:
  - No requests issued; the queue still drains to decode.
  - halted=1 while state=HALT and the queue is empty.
  - Only a redirect or reset leaves HALT; redirect clears halted on the next edge.
- Words returned outside REQ/DRAIN (spurious ack) are ignored.

Test Plan:
- Zero-latency memory (ack same cycle), out_ready=1, words at 0x0,0x4,0x8 -> out_pc 0,4,8 on consecutive cycles once streaming; one mem_req per cycle; no bubbles.
- 3-cycle ack latency, out_ready=0, QUEUE_DEPTH=2 -> exactly 2 acks, then mem_req=0; queue holds pc 0 and 4. Raise out_ready -> fetching resumes at 0x8.
- redirect_valid with redirect_pc=0x43 while a request to 0x8 is pending -> queue flushed; the ack for 0x8 is discarded; next mem_addr=0x40; first out_pc=0x40.
- Redirect and mem_ack on the same edge -> that word is never presented; next request at the redirect target.
- Memory returns 32'h00100073 at 0x1C -> no request to 0x20. halted=1 only after 0x1C is popped. Redirect to 0x0 -> halted=0 and fetch restarts at 0x0.
- Assert rst during an outstanding request with ack pending -> mem_req and out_valid drop immediately; after release, first request is to RESET_PC.
